fsmc_bus_master: RTL and testbench



---
 rtl/fsmc_bus_master.sv | 168 ++++++++++++++++
 tb/tb_fsmc_bus_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_bus_master.sv
// FSMC-style asynchronous SRAM bus initiator: runs one read or write bus cycle per
// command, with programmable address-setup, strobe and turnaround lengths.
module fsmc_bus_master #(
    parameter int unsigned ADRW = 2,
    parameter int unsigned DATW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      addset,
    input  logic [7:0]      datast,
    input  logic [3:0]      busturn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ADRW-1:0] cmd_adr,
    input  logic [DATW-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [DATW-1:0] rsp_rdata,
    output logic            aNE,
    output logic            aNOE,
    output logic            aNWE,
    output logic [ADRW-1:0] aAn,
    output logic [DATW-1:0] d_out,
    output logic            d_oe,
    input  logic [DATW-1:0] d_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    logic [1:0]      state_q,     state_d;
    logic [7:0]      cnt_q,       cnt_d;
    logic            write_q,     write_d;
    logic [7:0]      datast_q,    datast_d;
    logic [3:0]      busturn_q,   busturn_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DATW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            ne_q,        ne_d;
    logic            noe_q,       noe_d;
    logic            nwe_q,       nwe_d;
    logic [ADRW-1:0] adr_q,       adr_d;
    logic [DATW-1:0] dout_q,      dout_d;
    logic            doe_q,       doe_d;

    // Next-state and next-output logic; every bus pin is the output of a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        datast_d    = datast_q;
        busturn_d   = busturn_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ne_d        = ne_q;
        noe_d       = noe_q;
        nwe_d       = nwe_q;
        adr_d       = adr_q;
        dout_d      = dout_q;
        doe_d       = doe_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_ADDR;
                    cnt_d       = 8'(addset);
                    write_d     = cmd_write;
                    datast_d    = datast;
                    busturn_d   = busturn;
                    adr_d       = cmd_adr;
                    ne_d        = 1'b0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        dout_d = cmd_wdata;
                    end
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DATA;
                    cnt_d   = datast_q;
                    if (write_q) begin
                        nwe_d = 1'b0;
                        doe_d = 1'b1;
                    end else begin
                        noe_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                // Strobe and chip enable release together; read data sampled on the same edge.
                if (cnt_q == 8'd0) begin
                    state_d     = S_TURN;
                    cnt_d       = 8'(busturn_q);
                    ne_d        = 1'b1;
                    noe_d       = 1'b1;
                    nwe_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (!write_q) begin
                        rsp_rdata_d = d_in;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                // Write data stays driven through the first turnaround cycle as hold time.
                doe_d = 1'b0;
                if (cnt_q == 8'd0) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            write_q     <= 1'b0;
            datast_q    <= 8'd0;
            busturn_q   <= 4'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ne_q        <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            adr_q       <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            datast_q    <= datast_d;
            busturn_q   <= busturn_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ne_q        <= ne_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            adr_q       <= adr_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign aNE       = ne_q;
    assign aNOE      = noe_q;
    assign aNWE      = nwe_q;
    assign aAn       = adr_q;
    assign d_out     = dout_q;
    assign d_oe      = doe_q;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Testbench for fsmc_bus_master: commands are expanded into expected per-cycle bus
// waveforms from phase lengths and compared every cycle, plus scenario-specific checks.
module tb_fsmc_bus_master;

    localparam int unsigned ADRW = 2;
    localparam int unsigned DATW = 3;
    localparam int MAXC = 1024;

    logic            clk;
    logic            rst;
    logic [3:0]      addset;
    logic [7:0]      datast;
    logic [3:0]      busturn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [ADRW-1:0] cmd_adr;
    logic [DATW-1:0] cmd_wdata;
    logic            rsp_valid;
    logic [DATW-1:0] rsp_rdata;
    logic            aNE;
    logic            aNOE;
    logic            aNWE;
    logic [ADRW-1:0] aAn;
    logic [DATW-1:0] d_out;
    logic            d_oe;
    logic [DATW-1:0] d_in;

    fsmc_bus_master #(.ADRW(ADRW), .DATW(DATW)) dut (
        .clk(clk), .rst(rst),
        .addset(addset), .datast(datast), .busturn(busturn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aAn(aAn),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Expected waveform per cycle index (cycle 0 = idle cycle of first accept)
    bit              e_ne[MAXC], e_noe[MAXC], e_nwe[MAXC], e_oe[MAXC], e_rv[MAXC], e_rdy[MAXC], e_achk[MAXC];
    logic [ADRW-1:0] e_adr[MAXC];
    logic [DATW-1:0] e_dout[MAXC];
    // Observed values per cycle
    bit              o_ne[MAXC], o_noe[MAXC], o_nwe[MAXC], o_oe[MAXC], o_rv[MAXC], o_rdy[MAXC];
    logic [DATW-1:0] o_rdata[MAXC];
    logic [DATW-1:0] din_hist[MAXC];
    logic [DATW-1:0] din_script[MAXC];

    bit              c_wr[2];
    logic [ADRW-1:0] c_adr[2];
    logic [DATW-1:0] c_wd[2];
    int              c_as[2], c_ds[2], c_bt[2], c_start[2], c_send[2];

    logic [DATW-1:0] mem[4];
    int              din_mode;   // 0 random, 1 emulated SRAM, 2 scripted
    logic [DATW-1:0] exp_rdata;
    int              last_total;

    task automatic fill_idle(input int c);
        e_ne[c] = 1; e_noe[c] = 1; e_nwe[c] = 1; e_oe[c] = 0;
        e_rv[c] = 0; e_rdy[c] = 1; e_achk[c] = 0;
    endtask

    // Lay out one transaction's expected waveform; returns index of following idle cycle.
    task automatic add_txn(input int i, output int idle_c);
        int a, d, t, c;
        a = c_as[i] + 1; d = c_ds[i] + 1; t = c_bt[i] + 1;
        for (int k = 1; k <= a + d + t; k++) begin
            c = c_start[i] + k;
            e_rdy[c] = 0; e_achk[c] = 1; e_adr[c] = c_adr[i]; e_dout[c] = c_wd[i];
            e_ne[c] = 1; e_noe[c] = 1; e_nwe[c] = 1; e_oe[c] = 0; e_rv[c] = 0;
            if (k <= a) begin
                e_ne[c] = 0;
            end else if (k <= a + d) begin
                e_ne[c] = 0;
                if (c_wr[i]) begin e_nwe[c] = 0; e_oe[c] = 1; end
                else e_noe[c] = 0;
            end else if (k == a + d + 1) begin
                e_rv[c] = 1; e_oe[c] = c_wr[i];
            end
        end
        c_send[i] = c_start[i] + a + d;
        idle_c = c_start[i] + a + d + t + 1;
        fill_idle(idle_c);
    endtask

    // Drive n commands (second one queued behind the first) and compare every cycle.
    task automatic run_cmds(input int n);
        int total, pend;
        c_start[0] = 0;
        fill_idle(0);
        add_txn(0, total);
        if (n == 2) begin
            c_start[1] = total;
            add_txn(1, total);
        end
        last_total = total;
        for (int cyc = 0; cyc <= total; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < n; i++) begin
                if (cyc == c_send[i] + 1) begin
                    if (c_wr[i]) mem[c_adr[i]] = c_wd[i];
                    else exp_rdata = din_hist[c_send[i]];
                end
            end
            n_tests += 7;
            if (aNE !== e_ne[cyc]) begin n_fail++; $display("FAIL aNE cyc=%0d got=%b exp=%b", cyc, aNE, e_ne[cyc]); end
            if (aNOE !== e_noe[cyc]) begin n_fail++; $display("FAIL aNOE cyc=%0d got=%b exp=%b", cyc, aNOE, e_noe[cyc]); end
            if (aNWE !== e_nwe[cyc]) begin n_fail++; $display("FAIL aNWE cyc=%0d got=%b exp=%b", cyc, aNWE, e_nwe[cyc]); end
            if (d_oe !== e_oe[cyc]) begin n_fail++; $display("FAIL d_oe cyc=%0d got=%b exp=%b", cyc, d_oe, e_oe[cyc]); end
            if (rsp_valid !== e_rv[cyc]) begin n_fail++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rv[cyc]); end
            if (cmd_ready !== e_rdy[cyc]) begin n_fail++; $display("FAIL cmd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, e_rdy[cyc]); end
            if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rsp_rdata cyc=%0d got=%b exp=%b", cyc, rsp_rdata, exp_rdata); end
            if (e_achk[cyc]) begin
                n_tests++;
                if (aAn !== e_adr[cyc]) begin n_fail++; $display("FAIL aAn cyc=%0d got=%0d exp=%0d", cyc, aAn, e_adr[cyc]); end
            end
            if (e_oe[cyc]) begin
                n_tests++;
                if (d_out !== e_dout[cyc]) begin n_fail++; $display("FAIL d_out cyc=%0d got=%b exp=%b", cyc, d_out, e_dout[cyc]); end
            end
            n_tests++;
            if ((aNOE === 1'b0 && aNWE === 1'b0) || (aNE === 1'b1 && (aNOE === 1'b0 || aNWE === 1'b0))) begin
                n_fail++; $display("FAIL strobe_invariant cyc=%0d got ne/noe/nwe=%b%b%b exp=no overlap", cyc, aNE, aNOE, aNWE);
            end
            o_ne[cyc] = aNE; o_noe[cyc] = aNOE; o_nwe[cyc] = aNWE; o_oe[cyc] = d_oe;
            o_rv[cyc] = rsp_valid; o_rdy[cyc] = cmd_ready; o_rdata[cyc] = rsp_rdata;
            pend = -1;
            for (int i = n - 1; i >= 0; i--) if (c_start[i] >= cyc) pend = i;
            if (pend >= 0) begin
                cmd_valid = 1'b1; cmd_write = c_wr[pend]; cmd_adr = c_adr[pend]; cmd_wdata = c_wd[pend];
                addset = 4'(c_as[pend]); datast = 8'(c_ds[pend]); busturn = 4'(c_bt[pend]);
            end else begin
                // Idle command inputs wander to show mid-transaction changes are ignored.
                cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_adr = ADRW'($urandom);
                cmd_wdata = DATW'($urandom); addset = 4'($urandom); datast = 8'($urandom); busturn = 4'($urandom);
            end
            case (din_mode)
                1: d_in = mem[aAn];
                2: d_in = din_script[cyc];
                default: d_in = DATW'($urandom);
            endcase
            din_hist[cyc] = d_in;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic set_cmd(input int i, input bit wr, input int adr, input int wd, input int as, input int ds, input int bt);
        c_wr[i] = wr; c_adr[i] = ADRW'(adr); c_wd[i] = DATW'(wd);
        c_as[i] = as; c_ds[i] = ds; c_bt[i] = bt;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_wdata = '0;
        addset = '0; datast = '0; busturn = '0; d_in = '0;
        repeat (2) @(negedge clk);
        n_tests += 10;
        if (aNE !== 1'b1) begin n_fail++; $display("FAIL rst_aNE got=%b exp=1", aNE); end
        if (aNOE !== 1'b1) begin n_fail++; $display("FAIL rst_aNOE got=%b exp=1", aNOE); end
        if (aNWE !== 1'b1) begin n_fail++; $display("FAIL rst_aNWE got=%b exp=1", aNWE); end
        if (aAn !== 2'd0) begin n_fail++; $display("FAIL rst_aAn got=%0d exp=0", aAn); end
        if (d_out !== 3'd0) begin n_fail++; $display("FAIL rst_d_out got=%0d exp=0", d_out); end
        if (d_oe !== 1'b0) begin n_fail++; $display("FAIL rst_d_oe got=%b exp=0", d_oe); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_rdata !== 3'd0) begin n_fail++; $display("FAIL rst_rsp_rdata got=%0d exp=0", rsp_rdata); end
        rst = 1'b0;
        @(negedge clk);
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
        exp_rdata = '0;
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 2'd1; cmd_wdata = 3'b010;
        addset = 4'd0; datast = 8'd3; busturn = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (aNWE !== 1'b0) begin n_fail++; $display("FAIL mid_pre_nwe got=%b exp=0", aNWE); end
        #2 rst = 1'b1;
        #1;
        if (aNE !== 1'b1) begin n_fail++; $display("FAIL mid_async_ne got=%b exp=1", aNE); end
        if (aNWE !== 1'b1) begin n_fail++; $display("FAIL mid_async_nwe got=%b exp=1", aNWE); end
        if (d_oe !== 1'b0) begin n_fail++; $display("FAIL mid_async_doe got=%b exp=0", d_oe); end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests += 3;
            if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready k=%0d got=%b exp=1", k, cmd_ready); end
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp k=%0d got=%b exp=0", k, rsp_valid); end
            if (aNE !== 1'b1) begin n_fail++; $display("FAIL mid_ne k=%0d got=%b exp=1", k, aNE); end
        end
    endtask

    task automatic test_write_timing;
        int ne_low;
        din_mode = 0;
        set_cmd(0, 1'b1, 2, 3'b101, 1, 2, 0);
        run_cmds(1);
        ne_low = 0;
        for (int c = 1; c <= 7; c++) begin
            if (o_ne[c] == 1'b0) ne_low++;
            n_tests += 4;
            if (o_nwe[c] !== ((c >= 3 && c <= 5) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL wt_nwe c=%0d got=%b", c, o_nwe[c]); end
            if (o_oe[c] !== ((c >= 3 && c <= 6) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL wt_doe c=%0d got=%b", c, o_oe[c]); end
            if (o_rv[c] !== (c == 6)) begin n_fail++; $display("FAIL wt_rsp c=%0d got=%b", c, o_rv[c]); end
            if (o_rdy[c] !== (c == 7)) begin n_fail++; $display("FAIL wt_ready c=%0d got=%b", c, o_rdy[c]); end
        end
        n_tests++;
        if (ne_low != 5) begin n_fail++; $display("FAIL wt_ne_len got=%0d exp=5", ne_low); end
    endtask

    task automatic test_read_capture;
        // Strobe cycles 2..6; d_in turns 011 at cycle 5 and changes again at cycle 7.
        for (int c = 0; c < 10; c++) din_script[c] = (c < 5) ? 3'b000 : ((c < 7) ? 3'b011 : 3'b100);
        din_mode = 2;
        set_cmd(0, 1'b0, 3, 0, 0, 4, 1);
        run_cmds(1);
        n_tests += 2;
        if (o_rv[7] !== 1'b1) begin n_fail++; $display("FAIL rc_valid got=%b exp=1", o_rv[7]); end
        if (o_rdata[7] !== 3'b011) begin n_fail++; $display("FAIL rc_data got=%b exp=011", o_rdata[7]); end
        din_mode = 0;
    endtask

    task automatic test_back_to_back;
        int idle_cnt;
        din_mode = 0;
        set_cmd(0, 1'b1, 1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
        set_cmd(1, 1'b0, 2, 0, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
        run_cmds(2);
        idle_cnt = 0;
        for (int c = 1; c < last_total; c++) if (o_rdy[c]) idle_cnt++;
        n_tests++;
        if (idle_cnt != 1) begin n_fail++; $display("FAIL b2b_idle got=%0d exp=1", idle_cnt); end
    endtask

    task automatic test_max_length;
        int noe_low;
        din_mode = 0;
        set_cmd(0, 1'b0, 0, 0, $urandom_range(0, 3), 255, $urandom_range(0, 3));
        run_cmds(1);
        noe_low = 0;
        for (int c = 0; c <= last_total; c++) if (o_noe[c] == 1'b0) noe_low++;
        n_tests++;
        if (noe_low != 256) begin n_fail++; $display("FAIL max_noe_len got=%0d exp=256", noe_low); end
    endtask

    task automatic test_loopback;
        logic [DATW-1:0] want[3];
        want[0] = 3'b110; want[1] = 3'b100; want[2] = 3'b011;
        mem[0] = 3'b000; mem[1] = 3'b001; mem[2] = 3'b100; mem[3] = 3'b011;
        din_mode = 1;
        set_cmd(0, 1'b1, 1, 3'b110, $urandom_range(0, 2), 7, $urandom_range(0, 2));
        run_cmds(1);
        for (int r = 0; r < 3; r++) begin
            set_cmd(0, 1'b0, r + 1, 0, $urandom_range(0, 2), 7, $urandom_range(0, 2));
            run_cmds(1);
            n_tests++;
            if (o_rdata[c_send[0] + 1] !== want[r]) begin
                n_fail++; $display("FAIL loop_read adr=%0d got=%b exp=%b", r + 1, o_rdata[c_send[0] + 1], want[r]);
            end
        end
        din_mode = 0;
    endtask

    task automatic test_random;
        int n;
        din_mode = 0;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) begin
                set_cmd(i, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7),
                        $urandom_range(0, 15), $urandom_range(0, 10), $urandom_range(0, 15));
            end
            run_cmds(n);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; din_mode = 0; exp_rdata = '0;
        test_reset();
        test_write_timing();
        test_read_capture();
        test_back_to_back();
        test_max_length();
        test_loopback();
        test_random();
        test_reset_mid_write();
        test_write_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
